// File: rtl/dcache_mem_port_arbiter_if.sv
// rtl/dcache_mem_port_arbiter_if.sv - requester and memory-side bus bundle for the dcache memory port arbiter
//
// Purpose: groups the per-requester request/grant/response signals and the
// shared downstream memory port into one bundle.
//   slave  : arbiter view (takes requests and memory responses, drives grants,
//            responses and the downstream request).
//   master : environment view (requesters plus memory adapter).
// Per-port fields are flattened, with port p in slice [p*W +: W].

interface dcache_mem_port_arbiter_if #(
  parameter int NumPorts  = 3,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int IdWidth   = 1
);
  localparam int BeWidth = DataWidth / 8;

  // requester side
  logic [NumPorts-1:0]           req_i;
  logic [NumPorts-1:0]           we_i;
  logic [NumPorts*AddrWidth-1:0] addr_i;
  logic [NumPorts*DataWidth-1:0] wdata_i;
  logic [NumPorts*BeWidth-1:0]   be_i;
  logic [NumPorts-1:0]           gnt_o;
  logic [NumPorts-1:0]           rvalid_o;
  logic [DataWidth-1:0]          rdata_o;

  // memory side
  logic                          mem_req_o;
  logic                          mem_we_o;
  logic [AddrWidth-1:0]          mem_addr_o;
  logic [DataWidth-1:0]          mem_wdata_o;
  logic [BeWidth-1:0]            mem_be_o;
  logic [IdWidth-1:0]            mem_id_o;
  logic                          mem_gnt_i;
  logic                          mem_rvalid_i;
  logic [IdWidth-1:0]            mem_rid_i;
  logic [DataWidth-1:0]          mem_rdata_i;

  // status
  logic                          busy_o;
  logic                          protocol_err_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rid_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_id_o,
    output busy_o, protocol_err_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    output mem_gnt_i, mem_rvalid_i, mem_rid_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_id_o,
    input  busy_o, protocol_err_o
  );
endinterface

// File: rtl/dcache_mem_port_arbiter.sv
// rtl/dcache_mem_port_arbiter.sv - round-robin arbiter sharing the WT dcache memory port with ID-tagged responses
//
// Purpose: picks one of NumPorts requesters per cycle (round robin), tags the
// accepted transaction with the lowest free ID, remembers which port owns each
// ID and steers the returning response back to that port.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : slave modport of dcache_mem_port_arbiter_if (requesters, memory
//            port, busy_o, protocol_err_o)

module dcache_mem_port_arbiter #(
  parameter int NumPorts  = 3,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int IdWidth   = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  dcache_mem_port_arbiter_if.slave   bus
);

  localparam int NumIds   = 1 << IdWidth;
  localparam int PtrWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int BeWidth  = DataWidth / 8;

  // state
  logic [PtrWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic                lock_q, lock_d;
  logic [PtrWidth-1:0] lock_port_q, lock_port_d;
  logic [NumIds-1:0]   id_busy_q, id_busy_d;
  logic [PtrWidth-1:0] id_owner_q [NumIds];
  logic [PtrWidth-1:0] id_owner_d [NumIds];
  logic                err_q, err_d;

  // combinational datapath
  logic [PtrWidth-1:0]  sel;
  logic                 sel_valid;
  logic                 free_any;
  logic [IdWidth-1:0]   free_id;
  logic                 mem_req;
  logic                 accept;
  logic                 rsp_hit;
  logic [NumPorts-1:0]  gnt;
  logic [NumPorts-1:0]  rvalid;
  logic [DataWidth-1:0] rdata;
  logic                 mem_we;
  logic [AddrWidth-1:0] mem_addr;
  logic [DataWidth-1:0] mem_wdata;
  logic [BeWidth-1:0]   mem_be;
  int                   scan_idx;

  always_comb begin
    // ID allocation looks only at registered busy bits, so an ID released by
    // a response this cycle is not handed out again until the next cycle.
    free_any = ~&id_busy_q;
    free_id  = '0;
    for (int i = NumIds - 1; i >= 0; i--) begin
      if (!id_busy_q[IdWidth'(i)]) free_id = IdWidth'(i);
    end

    // Port selection: a locked request is re-presented unchanged; otherwise
    // scan from rr_ptr upward with wrap, only while an ID is available.
    sel       = '0;
    sel_valid = 1'b0;
    scan_idx  = 0;
    if (lock_q) begin
      sel       = lock_port_q;
      sel_valid = 1'b1;
    end else if (free_any) begin
      for (int i = 0; i < NumPorts; i++) begin
        scan_idx = int'(rr_ptr_q) + i;
        if (scan_idx >= NumPorts) scan_idx = scan_idx - NumPorts;
        if (!sel_valid && bus.req_i[PtrWidth'(scan_idx)]) begin
          sel_valid = 1'b1;
          sel       = PtrWidth'(scan_idx);
        end
      end
    end
    // Keep every output quiet while reset is asserted, even with live requests.
    if (!rst_ni) sel_valid = 1'b0;

    mem_req = sel_valid & free_any;
    accept  = mem_req & bus.mem_gnt_i;

    gnt = '0;
    if (accept) gnt[sel] = 1'b1;

    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (sel_valid) begin
      mem_we    = bus.we_i[sel];
      mem_addr  = bus.addr_i[int'(sel)*AddrWidth +: AddrWidth];
      mem_wdata = bus.wdata_i[int'(sel)*DataWidth +: DataWidth];
      mem_be    = bus.be_i[int'(sel)*BeWidth +: BeWidth];
    end

    // Response steering: only a response for an outstanding ID is forwarded.
    rsp_hit = rst_ni & bus.mem_rvalid_i & id_busy_q[bus.mem_rid_i];
    rvalid  = '0;
    rdata   = '0;
    if (rsp_hit) begin
      rvalid[id_owner_q[bus.mem_rid_i]] = 1'b1;
      rdata                             = bus.mem_rdata_i;
    end

    // next state
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    lock_port_d = lock_port_q;
    id_busy_d   = id_busy_q;
    id_owner_d  = id_owner_q;
    err_d       = err_q;

    if (rsp_hit) id_busy_d[bus.mem_rid_i] = 1'b0;
    if (bus.mem_rvalid_i && !id_busy_q[bus.mem_rid_i]) err_d = 1'b1;

    // Accept and response can coincide; the accepted ID is free and the
    // responding ID is busy, so the two updates never touch the same entry.
    if (accept) begin
      id_busy_d[free_id]  = 1'b1;
      id_owner_d[free_id] = sel;
      rr_ptr_d            = (sel == PtrWidth'(NumPorts - 1)) ? '0 : sel + PtrWidth'(1);
      lock_d              = 1'b0;
    end else if (mem_req) begin
      lock_d      = 1'b1;
      lock_port_d = sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_port_q <= '0;
      id_busy_q   <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < NumIds; i++) id_owner_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
      id_busy_q   <= id_busy_d;
      err_q       <= err_d;
      for (int i = 0; i < NumIds; i++) id_owner_q[i] <= id_owner_d[i];
    end
  end

  assign bus.gnt_o          = gnt;
  assign bus.rvalid_o       = rvalid;
  assign bus.rdata_o        = rdata;
  assign bus.mem_req_o      = mem_req;
  assign bus.mem_we_o       = mem_we;
  assign bus.mem_addr_o     = mem_addr;
  assign bus.mem_wdata_o    = mem_wdata;
  assign bus.mem_be_o       = mem_be;
  assign bus.mem_id_o       = free_id;
  assign bus.busy_o         = |id_busy_q;
  assign bus.protocol_err_o = err_q;

endmodule
